// File: rtl/prince_mlayer_serial.sv
// PRINCE M' linear layer with optional (inverse) ShiftRows, applied one 16-bit
// chunk per cycle to every Boolean share independently. Bit 0 = MSB of a share.
module prince_mlayer_share #(
  parameter int SR_EN  = 1,
  parameter int SR_INV = 0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_load,
  input  logic        i_proc,
  input  logic        i_last,
  input  logic        i_clr,
  input  logic [1:0]  i_cnt,
  input  logic [63:0] i_data,
  output logic [63:0] o_data
);
  // Ascending vectors so index k is the k-th bit counted from the MSB.
  logic [0:63] w_in, r_work, r_out, w_work_nxt, w_sr, w_res;
  logic [0:15] w_chunk, w_mix;
  logic        w_m1;

  function automatic logic [0:15] mix(input logic [0:15] x, input logic m1);
    logic [0:15] y;
    int          e;
    y = '0;
    for (int r = 0; r < 4; r++) begin
      for (int j = 0; j < 4; j++) begin
        e = (j - r - (m1 ? 1 : 0) + 8) % 4;
        for (int n = 0; n < 4; n++)
          if (n != e) y[4*r+j] = y[4*r+j] ^ x[4*n+j];
      end
    end
    return y;
  endfunction

  assign w_in    = i_data;
  assign o_data  = r_out;
  assign w_m1    = (i_cnt == 2'd1) || (i_cnt == 2'd2);
  assign w_chunk = r_work[16*i_cnt +: 16];
  assign w_mix   = mix(w_chunk, w_m1);

  always_comb begin
    w_work_nxt = r_work;
    w_work_nxt[16*i_cnt +: 16] = w_mix;
  end

  // Forward SR takes nibble 5i mod 16, the inverse takes 13i mod 16.
  always_comb begin
    w_sr = '0;
    for (int i = 0; i < 16; i++)
      w_sr[4*i +: 4] = w_work_nxt[4*(((SR_INV != 0) ? 13*i : 5*i) % 16) +: 4];
  end

  assign w_res = (SR_EN != 0) ? w_sr : w_work_nxt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_work <= '0;
      r_out  <= '0;
    end else begin
      if (i_load)      r_work <= w_in;
      else if (i_proc) r_work <= w_work_nxt;
      if (i_last)      r_out  <= w_res;
      else if (i_clr)  r_out  <= '0;
    end
  end
endmodule

module prince_mlayer_serial #(
  parameter int SHARES = 3,
  parameter int SR_EN  = 1,
  parameter int SR_INV = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [64*SHARES-1:0]  i_state,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [64*SHARES-1:0]  o_state
);
  typedef enum logic [1:0] {S_IDLE, S_PROC, S_DONE} state_t;

  state_t     r_state, w_next;
  logic [1:0] r_cnt;
  logic       w_load, w_proc, w_last, w_clr;

  assign w_load = (r_state == S_IDLE) && i_valid;
  assign w_proc = (r_state == S_PROC);
  assign w_last = w_proc && (r_cnt == 2'd3);
  assign w_clr  = (r_state == S_DONE) && i_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 2'd0;
    end else begin
      r_state <= w_next;
      if (w_load)      r_cnt <= 2'd0;
      else if (w_proc) r_cnt <= r_cnt + 2'd1;
    end
  end

  always_comb begin
    w_next  = r_state;
    o_ready = 1'b0;
    o_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_ready = 1'b1;
        if (i_valid) w_next = S_PROC;
      end
      S_PROC: if (r_cnt == 2'd3) w_next = S_DONE;
      S_DONE: begin
        o_valid = 1'b1;
        if (i_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  for (genvar s = 0; s < SHARES; s++) begin : g_share
    prince_mlayer_share #(.SR_EN(SR_EN), .SR_INV(SR_INV)) u_share (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_load (w_load),
      .i_proc (w_proc),
      .i_last (w_last),
      .i_clr  (w_clr),
      .i_cnt  (r_cnt),
      .i_data (i_state[64*s +: 64]),
      .o_data (o_state[64*s +: 64])
    );
  end
endmodule

// File: tb/tb_prince_mlayer_serial.sv
// Randomized bench: three configurations (SR, no SR, inverse SR) driven in lockstep
// and checked against a block-matrix PRINCE M' reference model.
module tb_prince_mlayer_serial;
  logic         i_clk = 1'b0;
  logic         i_rst, i_valid, i_ready;
  logic [191:0] i_state;
  logic         rdy_a, rdy_b, rdy_c, vld_a, vld_b, vld_c;
  logic [191:0] out_a, out_b, out_c;
  int           n_chk = 0, n_err = 0;

  always #5 i_clk = ~i_clk;

  prince_mlayer_serial #(.SHARES(3), .SR_EN(1), .SR_INV(0)) u_sr (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(rdy_a),
    .i_state(i_state), .o_valid(vld_a), .i_ready(i_ready), .o_state(out_a));
  prince_mlayer_serial #(.SHARES(3), .SR_EN(0), .SR_INV(0)) u_nosr (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(rdy_b),
    .i_state(i_state), .o_valid(vld_b), .i_ready(i_ready), .o_state(out_b));
  prince_mlayer_serial #(.SHARES(3), .SR_EN(1), .SR_INV(1)) u_inv (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(rdy_c),
    .i_state(i_state), .o_valid(vld_c), .i_ready(i_ready), .o_state(out_c));

  task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Big-endian bit access: b = 0 is the MSB of the 64-bit share.
  function automatic logic gb(input logic [63:0] v, input int b);
    return v[63-b];
  endfunction

  // PRINCE block form: block (r,n) of M^m is the 4x4 identity with diagonal entry
  // (r+n+m) mod 4 cleared.
  function automatic logic [63:0] mprime(input logic [63:0] x);
    logic [63:0] y;
    int m, k;
    y = '0;
    for (int c = 0; c < 4; c++) begin
      m = (c == 1 || c == 2) ? 1 : 0;
      for (int r = 0; r < 4; r++)
        for (int n = 0; n < 4; n++) begin
          k = (r + n + m) % 4;
          for (int j = 0; j < 4; j++)
            if (j != k) y[63-(16*c+4*r+j)] = y[63-(16*c+4*r+j)] ^ gb(x, 16*c+4*n+j);
        end
    end
    return y;
  endfunction

  function automatic logic [63:0] shrows(input logic [63:0] x, input bit inv);
    int pf[16] = '{0,5,10,15,4,9,14,3,8,13,2,7,12,1,6,11};
    int pi[16] = '{0,13,10,7,4,1,14,11,8,5,2,15,12,9,6,3};
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 16; i++)
      for (int t = 0; t < 4; t++)
        y[63-(4*i+t)] = gb(x, 4*(inv ? pi[i] : pf[i]) + t);
    return y;
  endfunction

  function automatic logic [191:0] model(input logic [191:0] st, input bit sr, input bit inv);
    logic [191:0] y;
    logic [63:0]  v;
    for (int s = 0; s < 3; s++) begin
      v = mprime(st[64*s +: 64]);
      y[64*s +: 64] = sr ? shrows(v, inv) : v;
    end
    return y;
  endfunction

  function automatic logic [191:0] rnd192();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_rdy"}, {189'd0, rdy_a, rdy_b, rdy_c}, 192'd7);
    chk({tag, "_vld"}, {189'd0, vld_a, vld_b, vld_c}, 192'd0);
    chk({tag, "_oa"}, out_a, '0);
    chk({tag, "_ob"}, out_b, '0);
    chk({tag, "_oc"}, out_c, '0);
  endtask

  // One full transaction with a chosen number of back-pressure cycles in DONE.
  task automatic run_block(input logic [191:0] st, input int hold, input bit detail);
    logic [191:0] ea, eb, ec, xin, xout;
    ea = model(st, 1, 0);
    eb = model(st, 0, 0);
    ec = model(st, 1, 1);
    chk("acc_rdy", {191'd0, rdy_a}, 192'd1);
    i_state = st; i_valid = 1'b1; i_ready = 1'b1;
    tick();
    for (int c = 0; c < 4; c++) begin
      i_state = rnd192(); i_valid = $urandom_range(0, 1);
      if (detail || c == 0)
        chk("proc_hs", {188'd0, rdy_a, rdy_b, rdy_c, vld_a}, 192'd0);
      tick();
    end
    i_valid = 1'b0;
    i_ready = (hold == 0);
    chk("done_vld", {189'd0, vld_a, vld_b, vld_c}, 192'd7);
    chk("out_sr", out_a, ea);
    chk("out_nosr", out_b, eb);
    chk("out_inv", out_c, ec);
    xin  = st[63:0] ^ st[127:64] ^ st[191:128];
    xout = out_a[63:0] ^ out_a[127:64] ^ out_a[191:128];
    chk("linear", {128'd0, xout[63:0]}, {128'd0, shrows(mprime(xin[63:0]), 0)});
    for (int h = 0; h < hold; h++) begin
      i_valid = $urandom_range(0, 1); i_state = rnd192();
      tick();
      i_ready = (h == hold - 1);
      chk("hold_hs", {189'd0, vld_a, rdy_a, rdy_b}, 192'd4);
      chk("hold_sr", out_a, ea);
      if (detail) chk("hold_inv", out_c, ec);
    end
    i_valid = 1'b0;
    tick();
    i_ready = 1'b0;
    check_idle("post");
  endtask

  initial begin
    logic [191:0] st;
    i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0; i_state = '0;
    tick(); tick();
    i_rst = 1'b0;
    check_idle("reset");

    // zero block, i_ready high: six-cycle round trip
    run_block('0, 0, 1);

    // single-bit directed vectors against the documented results
    run_block({128'd0, 64'h8000_0000_0000_0000}, 0, 1);
    chk("dir_s0", out_b, '0);
    i_state = {128'd0, 64'h8000_0000_0000_0000}; i_valid = 1'b1; i_ready = 1'b0;
    tick(); i_valid = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    chk("dir_share0", out_b, {128'd0, 64'h0888_0000_0000_0000});
    i_ready = 1'b1; tick(); i_ready = 1'b0;
    i_state = {64'd0, 64'h0000_8000_0000_0000, 64'd0}; i_valid = 1'b1;
    tick(); i_valid = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    chk("dir_share1", out_b, {64'd0, 64'h0000_8880_0000_0000, 64'd0});
    i_ready = 1'b1; tick(); i_ready = 1'b0;
    check_idle("dir_end");

    // back-pressure for 10 cycles
    run_block(rnd192(), 10, 1);

    // reset while processing chunk 2
    i_state = rnd192(); i_valid = 1'b1;
    tick(); i_valid = 1'b0;
    tick(); tick();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    check_idle("midrst");
    tick();
    check_idle("midrst2");
    run_block(rnd192(), 1, 1);

    for (int t = 0; t < 1000; t++) begin
      st = rnd192();
      if (t % 97 == 3) st[63:0] = 64'hFFFF_FFFF_FFFF_FFFF;
      run_block(st, $urandom_range(0, 2), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
